// File: rtl/prbs_pkg.sv
// prbs_pkg: pattern-mode encodings, per-mode LFSR lengths/taps/masks and default seed.
package prbs_pkg;
  localparam logic [1:0] MODE_PRBS7  = 2'd0;
  localparam logic [1:0] MODE_PRBS15 = 2'd1;
  localparam logic [1:0] MODE_PRBS31 = 2'd2;
  localparam logic [1:0] MODE_FIXED  = 2'd3;
  localparam int LEN7  = 7;
  localparam int LEN15 = 15;
  localparam int LEN31 = 31;
  localparam int TAP7_A  = 6;
  localparam int TAP7_B  = 5;
  localparam int TAP15_A = 14;
  localparam int TAP15_B = 13;
  localparam int TAP31_A = 30;
  localparam int TAP31_B = 27;
  localparam logic [30:0] MASK7  = 31'((64'd1 << LEN7) - 64'd1);
  localparam logic [30:0] MASK15 = 31'((64'd1 << LEN15) - 64'd1);
  localparam logic [30:0] MASK31 = 31'((64'd1 << LEN31) - 64'd1);
  localparam logic [30:0] DEFAULT_SEED = '1;
  function automatic logic [30:0] mode_mask(input logic [1:0] m);
    return m == MODE_PRBS7 ? MASK7 : m == MODE_PRBS15 ? MASK15 : MASK31;
  endfunction
endpackage

// File: rtl/prbs_word_gen.sv
// prbs_word_gen: unrolled WIDTH-step Fibonacci LFSR producing one word and the advanced state.
module prbs_word_gen
  import prbs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [30:0] SEED = DEFAULT_SEED
) (
  input  logic [30:0]      state,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] word,
  output logic [30:0]      next_state
);
  logic [30:0] mask;
  logic [30:0] s;
  logic fb;
  always_comb begin
    mask = mode_mask(mode);
    s = state & mask;
    fb = 1'b0;
    word = '0;
    // an all-zero masked state would lock up, so restart from the seed
    if (s == '0) s = SEED & mask;
    for (int i = 0; i < WIDTH; i++) begin
      fb = mode == MODE_PRBS7  ? s[TAP7_A] ^ s[TAP7_B] :
           mode == MODE_PRBS15 ? s[TAP15_A] ^ s[TAP15_B] : s[TAP31_A] ^ s[TAP31_B];
      word[WIDTH-1-i] = fb;
      s = {s[29:0], fb} & mask;
    end
    next_state = mode == MODE_FIXED ? state : s;
  end
endmodule

// File: rtl/prbs_serial_tx.sv
// prbs_serial_tx: selectable PRBS/fixed word generator with MSB-first serializer,
// error injection and enable gating, all in the bit-clock domain.
module prbs_serial_tx
  import prbs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [30:0] SEED = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             inject_err_i,
  output logic             serial_o,
  output logic             word_start_o,
  output logic [1:0]       mode_o
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr, gen_word, word;
  logic [30:0] lfsr, lfsr_next;
  logic pend, load;
  prbs_word_gen #(.WIDTH(WIDTH), .SEED(SEED)) u_gen (
    .state(lfsr), .mode(mode_i), .word(gen_word), .next_state(lfsr_next)
  );
  assign load = enable_i && cnt == '0;
  // corruption is applied after generation so the LFSR sequence is untouched
  assign word = (mode_i == MODE_FIXED ? pattern_i : gen_word)
              ^ {pend | inject_err_i, {(WIDTH-1){1'b0}}};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      sr <= '0;
      lfsr <= SEED;
      pend <= 1'b0;
      serial_o <= 1'b0;
      word_start_o <= 1'b0;
      mode_o <= MODE_PRBS7;
    end else if (!enable_i) begin
      cnt <= '0;
      serial_o <= 1'b0;
      word_start_o <= 1'b0;
    end else if (load) begin
      cnt <= CW'(1);
      sr <= word;
      lfsr <= lfsr_next;
      pend <= 1'b0;
      serial_o <= word[WIDTH-1];
      word_start_o <= 1'b1;
      mode_o <= mode_i;
    end else begin
      cnt <= cnt == CW'(WIDTH-1) ? '0 : cnt + CW'(1);
      sr <= sr << 1;
      pend <= pend | inject_err_i;
      serial_o <= sr[WIDTH-2];
      word_start_o <= 1'b0;
    end
endmodule
